top_blinking_machine: RTL and testbench
=======================================

TOP_BLINKING_MACHINE -- requirements
Module: top_blinking_machine

Parameters
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000: i_clk frequency in Hz.
REQ-002 SHALL have parameter OUT_FREQ, default 1: o_clk_1hz frequency in Hz.
REQ-003 SHALL have parameter BLINKS, default 3: on/off cycles per start request, range 1..255.
REQ-004 SHALL derive HALF = CLK_FREQ/(2*OUT_FREQ) (integer, >=1) and size all counters from HALF and BLINKS.

Interface
REQ-005 SHALL have i_clk, input, 1: single system clock; all logic on its rising edge, no derived clocks.
REQ-006 SHALL have i_rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have i_start, input, 1: synchronous start request, level-sampled each i_clk.
REQ-008 SHALL have o_out, output, 1: blink output, 1 = on.
REQ-009 SHALL have o_clk_1hz, output, 1: divided clock, 50% duty, registered.

Function
REQ-010 Divider: counter runs 0..HALF-1, wraps to 0 and toggles o_clk_1hz on the cycle it equals HALF-1; o_clk_1hz period = 2*HALF i_clk cycles.
REQ-011 Divider SHALL produce a one-i_clk tick on the cycle o_clk_1hz goes 0->1, used as FSM enable.
REQ-012 Divider SHALL run freely from reset release, independent of i_start and FSM state.
REQ-013 Pending flag: i_start=1 in IDLE sets pending on the next i_clk edge; pending clears when FSM leaves IDLE.
REQ-014 i_start while not in IDLE SHALL be ignored; requests are not queued.
REQ-015 FSM states IDLE, ON, OFF; transitions only on tick cycles.
REQ-016 IDLE: tick with pending=1 -> ON, blink counter := 1; otherwise stay.
REQ-017 ON: tick -> OFF.
REQ-018 OFF: tick with counter == BLINKS -> IDLE, counter := 0; otherwise -> ON, counter += 1.
REQ-019 o_out SHALL be registered and equal 1 exactly while FSM is in ON; it changes on the same i_clk edge as the state.
REQ-020 Each on-phase and off-phase SHALL last exactly 2*HALF i_clk cycles; a request yields exactly BLINKS on-pulses.
REQ-021 Start latency: first o_out rise at the first tick after pending is set (0 to 2*HALF cycles).
REQ-022 Tick and i_start in the same cycle in IDLE with pending=0 SHALL NOT start blinking on that tick; it sets pending for the next tick.

Reset
REQ-023 i_rst=0 SHALL immediately force o_out=0, o_clk_1hz=0, divider counter=0, blink counter=0, pending=0, FSM=IDLE.
REQ-024 Reset assertion mid-blink SHALL abort the sequence; after release no blinking occurs without a new i_start.
REQ-025 Reset release SHALL be handled synchronously; first divider increment on the first i_clk edge after release.

Verification (CLK_FREQ=20, OUT_FREQ=1, BLINKS=3, so HALF=10)
REQ-026 Hold i_rst=0 for 100 cycles -> o_out=0, o_clk_1hz=0 throughout.
REQ-027 Release reset with no i_start -> o_clk_1hz toggles every 10 cycles (period 20); o_out stays 0.
REQ-028 Pulse i_start high for 10 cycles -> o_out rises on the next tick; 3 on-pulses of 20 cycles separated by 20-cycle off gaps; then IDLE, o_out=0.
REQ-029 Pulse i_start again during the second on-pulse -> still exactly 3 pulses, no extra sequence afterward.
REQ-030 Assert i_rst=0 during the second on-pulse, release, no i_start -> o_out=0 immediately and stays 0; divider restarts from 0.
REQ-031 i_start=1 on the same cycle as a tick in IDLE -> o_out rises one o_clk_1hz period (20 cycles) later, not on that tick.

Source files
------------

// File: rtl/top_blinking_machine.sv
// Blink sequencer: a free-running divider makes a 50% duty slow clock plus a
// one-cycle tick on its rising edge; the FSM steps once per tick to emit BLINKS on/off pulses.
module top_blinking_machine #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int OUT_FREQ = 1,
  parameter int BLINKS   = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_out,
  output logic o_clk_1hz
);

  localparam int HALF_RAW = CLK_FREQ / (2 * OUT_FREQ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BLK_W    = $clog2(BLINKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINKS);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             clk_q, clk_d;
  logic             div_wrap;
  logic             tick;

  state_t           state_q;
  logic [BLK_W-1:0] blink_cnt_q;
  logic             pending_q;
  logic             out_q;

  // Tick fires on the very edge where the slow clock goes 0->1, so the FSM
  // and o_clk_1hz change together.
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    clk_d     = div_wrap ? ~clk_q : clk_q;
    tick      = div_wrap & ~clk_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_cnt_q <= '0;
      clk_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_q     <= clk_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      blink_cnt_q <= '0;
      pending_q   <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Only a request latched before this tick may start a sequence.
          if (tick && pending_q) begin
            state_q     <= ST_ON;
            blink_cnt_q <= BLK_ONE;
            pending_q   <= 1'b0;
            out_q       <= 1'b1;
          end else if (i_start) begin
            pending_q <= 1'b1;
          end
        end
        ST_ON: begin
          pending_q <= 1'b0;
          if (tick) begin
            state_q <= ST_OFF;
            out_q   <= 1'b0;
          end
        end
        ST_OFF: begin
          pending_q <= 1'b0;
          if (tick) begin
            if (blink_cnt_q == BLK_LAST) begin
              state_q     <= ST_IDLE;
              blink_cnt_q <= '0;
              out_q       <= 1'b0;
            end else begin
              state_q     <= ST_ON;
              blink_cnt_q <= blink_cnt_q + BLK_ONE;
              out_q       <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          blink_cnt_q <= '0;
          pending_q   <= 1'b0;
          out_q       <= 1'b0;
        end
      endcase
    end
  end

  assign o_out     = out_q;
  assign o_clk_1hz = clk_q;

endmodule

// File: tb/tb_top_blinking_machine.sv
// Self-checking bench for top_blinking_machine with HALF=10: expected waveforms
// are derived from the scenario table's predicted first-rise cycles.
`timescale 1ns/1ps
module tb_top_blinking_machine;

  localparam int CLK_FREQ = 20;
  localparam int OUT_FREQ = 1;
  localparam int BLINKS   = 3;
  localparam int HALF     = 10;
  localparam int PHASE    = 2 * HALF;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;
  logic out_w;
  logic clk1_w;

  always #5 clk = ~clk;

  top_blinking_machine #(
    .CLK_FREQ (CLK_FREQ),
    .OUT_FREQ (OUT_FREQ),
    .BLINKS   (BLINKS)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_start   (start),
    .o_out     (out_w),
    .o_clk_1hz (clk1_w)
  );

  // Cycle numbers count rising edges after reset release (first edge = 1).
  typedef struct {
    int start_at;
    int start_len;
    int re_at;
    int re_len;
    int len;
    int rise_a;
    int rise_b;
  } vec_t;

  typedef struct {
    int   n;
    logic out;
    logic clk1;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int n, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", name, n, act, exp);
  endtask

  function automatic logic in_seq(input int rise, input int n);
    if (rise <= 0) return 1'b0;
    for (int p = 0; p < BLINKS; p++) begin
      if (n >= rise + 2 * PHASE * p && n < rise + 2 * PHASE * p + PHASE) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic exp_clk(input int n);
    return ((n / HALF) % 2) == 1;
  endfunction

  function automatic logic active(input int at, input int len, input int n);
    return (len > 0) && (n >= at) && (n < at + len);
  endfunction

  task automatic hold_reset(input int cycles, input string tag);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, "_out_immediate"}, 0, out_w, 1'b0);
    check({tag, "_clk_immediate"}, 0, clk1_w, 1'b0);
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk);
      #1;
      check({tag, "_out_in_reset"}, c, out_w, 1'b0);
      check({tag, "_clk_in_reset"}, c, clk1_w, 1'b0);
    end
  endtask

  task automatic release_and_run(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= v.len; n++) begin
      if (n > 1) @(negedge clk);
      start  = active(v.start_at, v.start_len, n) || active(v.re_at, v.re_len, n);
      e.n    = n;
      e.out  = in_seq(v.rise_a, n) || in_seq(v.rise_b, n);
      e.clk1 = exp_clk(n);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check({tag, "_out"}, got.n, out_w, got.out);
      check({tag, "_clk1hz"}, got.n, clk1_w, got.clk1);
    end
    start = 1'b0;
  endtask

  initial begin
    vec_t abort_v;
    vec_t idle_v;

    // {start_at, start_len, re_at, re_len, len, rise_a, rise_b}
    vecs[0] = '{0,  0,  0,   0, 200, 0,  0};    // free-running divider, no blink
    vecs[1] = '{1,  10, 0,   0, 250, 10, 0};    // 10-cycle request
    vecs[2] = '{1,  10, 55,  6, 250, 10, 0};    // request during second on-pulse ignored
    vecs[3] = '{10, 1,  0,   0, 250, 30, 0};    // request on tick cycle waits a period
    vecs[4] = '{29, 1,  0,   0, 250, 30, 0};    // request one cycle before tick
    vecs[5] = '{31, 1,  0,   0, 250, 50, 0};    // request one cycle after tick
    vecs[6] = '{1,  1,  140, 1, 300, 10, 150};  // second request after sequence ends
    vecs[7] = '{1,  1,  130, 1, 300, 10, 0};    // request on the final OFF->IDLE edge ignored
    vecs[8] = '{1,  1,  131, 1, 300, 10, 150};  // request right after returning to IDLE

    hold_reset(100, "long_reset");
    for (int i = 0; i < 9; i++) begin
      release_and_run(vecs[i], $sformatf("vec%0d", i));
      hold_reset(5, $sformatf("vec%0d_rst", i));
    end

    // Abort in the middle of the second on-pulse, then release with no request.
    abort_v = '{1, 1, 0, 0, 55, 10, 0};
    idle_v  = '{0, 0, 0, 0, 200, 0, 0};
    release_and_run(abort_v, "abort_pre");
    hold_reset(100, "abort_rst");
    release_and_run(idle_v, "abort_post");

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
